bg_pixel_reader: RTL and testbench

BG_PIXEL_READER -- requirements
Module: bg_pixel_reader

---
 rtl/bg_pkg.sv | 42 ++++
 rtl/bg_palette.sv | 36 +++
 rtl/bg_pixel_reader.sv | 127 ++++++++++++
 tb/tb_bg_pixel_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared constants, colour type and palette for the background pixel reader.
package bg_pkg;

    localparam int IMG_W    = 20;
    localparam int IMG_H    = 20;
    localparam int TILE_W   = 32;
    localparam int TILE_H   = 24;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    // Highest row base a valid tile row can have (last image row * width).
    localparam int ROW_BASE_MAX = (IMG_H - 1) * IMG_W;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t PALETTE [0:7] = '{
        '{8'h00, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF},
        '{8'hFF, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'h00},
        '{8'h00, 8'h00, 8'hFF},
        '{8'h00, 8'hFF, 8'h00},
        '{8'hFF, 8'h00, 8'hFF},
        '{8'h00, 8'hFF, 8'hFF}
    };

    // Indices beyond the populated palette entries render black.
    function automatic rgb_t palette_lookup(input logic [4:0] idx);
        rgb_t c;
        c = '0;
        if (idx < 5'd8) begin
            c = PALETTE[idx[2:0]];
        end
        return c;
    endfunction

endpackage

// File: rtl/bg_palette.sv
// Registered palette stage: converts a 5-bit colour index into RGB,
// forcing black while the aligned blank flag is low.
module bg_palette
    import bg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] idx,
    input  logic       blank_n,
    output rgb_t       rgb
);

    rgb_t rgb_q;
    rgb_t rgb_d;

    // Next colour: only advances on a pixel strobe.
    always_comb begin
        rgb_d = rgb_q;
        if (en) begin
            rgb_d = blank_n ? palette_lookup(idx) : '0;
        end
    end

    // Colour register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/bg_pixel_reader.sv
// Background pixel reader: maps VGA coordinates onto a 20x20 tile image held
// in frame RAM, fetches the colour index and converts it to RGB through a
// three-stage pixel-strobe-gated pipeline with sync signals kept in step.
module bg_pixel_reader
    import bg_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_n_in,
    output logic [18:0] read_address,
    input  logic [4:0]  ram_data,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_n_out
);

    localparam logic [9:0] X_ACTIVE     = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACTIVE     = 10'(V_ACTIVE);
    localparam logic [9:0] X_LAST       = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST       = 10'(V_TOTAL - 1);
    localparam logic [4:0] SUB_LAST     = 5'(TILE_H - 1);
    localparam logic [8:0] ROW_STEP     = 9'(IMG_W);
    localparam logic [8:0] ROW_BASE_TOP = 9'(ROW_BASE_MAX);
    // {hs, vs, blank_n}: syncs idle high, blank asserted.
    localparam logic [2:0] SYNC_IDLE    = 3'b110;

    logic [4:0] sub_line_q, sub_line_d;
    logic [8:0] row_base_q, row_base_d;
    logic [8:0] addr_q,     addr_d;
    logic [2:0] sync0_q,    sync0_d;
    logic [4:0] idx_q,      idx_d;
    logic [2:0] sync1_q,    sync1_d;
    logic [2:0] sync2_q,    sync2_d;
    logic       line_end;
    logic       in_active;
    rgb_t       rgb;

    assign line_end  = pix_en && (DrawX == X_LAST);
    assign in_active = (DrawX < X_ACTIVE) && (DrawY < Y_ACTIVE);

    // Tile-row tracking: count 24 scanlines per tile row instead of dividing
    // DrawY; the base is clamped so a desynchronised frame cannot overrun.
    always_comb begin
        sub_line_d = sub_line_q;
        row_base_d = row_base_q;
        if (line_end) begin
            if (DrawY == Y_LAST) begin
                sub_line_d = '0;
                row_base_d = '0;
            end else if (DrawY < Y_ACTIVE) begin
                if (sub_line_q == SUB_LAST) begin
                    sub_line_d = '0;
                    if (row_base_q != ROW_BASE_TOP) begin
                        row_base_d = row_base_q + ROW_STEP;
                    end
                end else begin
                    sub_line_d = sub_line_q + 5'd1;
                end
            end
        end
    end

    // Pipeline stages S0 (address) and S1 (RAM capture) plus sync delay line.
    always_comb begin
        addr_d  = addr_q;
        sync0_d = sync0_q;
        idx_d   = idx_q;
        sync1_d = sync1_q;
        sync2_d = sync2_q;
        if (pix_en) begin
            addr_d  = in_active ? (row_base_q + {4'b0000, DrawX[9:5]}) : '0;
            sync0_d = {hs_in, vs_in, blank_n_in};
            idx_d   = ram_data;
            sync1_d = sync0_q;
            sync2_d = sync1_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sub_line_q <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            sync0_q    <= SYNC_IDLE;
            idx_q      <= '0;
            sync1_q    <= SYNC_IDLE;
            sync2_q    <= SYNC_IDLE;
        end else begin
            sub_line_q <= sub_line_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            sync0_q    <= sync0_d;
            idx_q      <= idx_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    // S2: palette register, blanked by the S1 copy of blank_n so colour and
    // blank_n_out leave on the same strobe.
    bg_palette u_palette (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .en      (pix_en),
        .idx     (idx_q),
        .blank_n (sync1_q[0]),
        .rgb     (rgb)
    );

    assign read_address = {10'b0, addr_q};
    assign Red          = rgb.r;
    assign Green        = rgb.g;
    assign Blue         = rgb.b;
    assign hs_out       = sync2_q[2];
    assign vs_out       = sync2_q[1];
    assign blank_n_out  = sync2_q[0];

endmodule

// File: tb/tb_bg_pixel_reader.sv
// Scoreboard bench for bg_pixel_reader: the driver pushes expected address and
// pixel entries per strobe, a monitor pops on each strobe and compares every cycle.
module tb_bg_pixel_reader;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs_in;
    logic        vs_in;
    logic        blank_n_in;
    logic [18:0] read_address;
    logic [4:0]  ram_data;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        hs_out;
    logic        vs_out;
    logic        blank_n_out;

    always #10 Clk = ~Clk;

    bg_pixel_reader dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_en       (pix_en),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .blank_n_in   (blank_n_in),
        .read_address (read_address),
        .ram_data     (ram_data),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .blank_n_out  (blank_n_out)
    );

    // Frame RAM model: registered read, one Clk of latency.
    logic [4:0] mem [0:511];
    always @(posedge Clk) ram_data <= mem[read_address[8:0]];

    typedef struct {
        bit         chk;
        logic [8:0] addr;
    } addr_exp_t;

    typedef struct {
        bit          chk;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } pix_exp_t;

    addr_exp_t aq[$];
    pix_exp_t  pq[$];
    addr_exp_t cur_a;
    pix_exp_t  cur_p;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    bit trust    = 1'b1;

    // Hand-computed addresses for the called-out coordinates.
    localparam int HX [0:6] = '{0, 31, 32, 639, 64, 639, 700};
    localparam int HY [0:6] = '{0, 0,  0,  0,   24, 479, 0};
    localparam int HA [0:6] = '{0, 0,  1,  19,  22, 399, 0};

    // X positions visited on each active line (sparse, including porch/hsync).
    localparam int XL [0:12] = '{0, 31, 32, 64, 160, 192, 300, 639, 656, 700, 701, 702, 799};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pal(input logic [4:0] i);
        case (i)
            5'd0:    return 24'h000000;
            5'd1:    return 24'hFFFFFF;
            5'd2:    return 24'hFF0000;
            5'd3:    return 24'hFFFF00;
            5'd4:    return 24'h0000FF;
            5'd5:    return 24'h00FF00;
            5'd6:    return 24'hFF00FF;
            5'd7:    return 24'h00FFFF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [8:0] model_addr(input int x, input int y);
        for (int i = 0; i < 7; i++) begin
            if (HX[i] == x && HY[i] == y) return 9'(HA[i]);
        end
        if (x < 640 && y < 480) return 9'((y / 24) * 20 + x / 32);
        return 9'd0;
    endfunction

    // Issue one strobe at the current negedge, then idle for 'idle' cycles.
    task automatic strobe(input int x, input int y, input int idle);
        addr_exp_t a;
        pix_exp_t  p;
        logic      bl;
        bl         = (x < 640 && y < 480);
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        hs_in      = !(x == 700 || x == 701);
        vs_in      = !(y == 490 || y == 491);
        blank_n_in = bl;
        pix_en     = 1'b1;
        a.chk  = trust;
        a.addr = model_addr(x, y);
        p.chk  = trust;
        p.hs   = hs_in;
        p.vs   = vs_in;
        p.bl   = bl;
        p.rgb  = bl ? pal(mem[a.addr]) : 24'h0;
        aq.push_back(a);
        pq.push_back(p);
        @(negedge Clk);
        if (idle > 0) begin
            pix_en = 1'b0;
            repeat (idle) @(negedge Clk);
        end
    endtask

    task automatic active_line(input int y, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            strobe(XL[i], y, (y == 5 && XL[i] == 160) ? 5 : 1);
        end
    endtask

    // Vertical blanking lines use back-to-back strobes.
    task automatic vblank_line(input int y);
        strobe(0,   y, 0);
        strobe(639, y, 0);
        strobe(700, y, 0);
        strobe(701, y, 1);
    endtask

    task automatic run_line(input int y);
        if (y < 480) active_line(y, 0, 12);
        else         vblank_line(y);
    endtask

    task automatic do_reset(input bit strobe_during);
        pix_exp_t r;
        mon_en  = 1'b0;
        Reset_n = 1'b0;
        pix_en  = strobe_during;
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk);
            #1;
            check("rst_read_address", 32'(read_address), 32'd0);
            check("rst_rgb", {8'h0, Red, Green, Blue}, 32'h0);
            check("rst_hs_out", 32'(hs_out), 32'd1);
            check("rst_vs_out", 32'(vs_out), 32'd1);
            check("rst_blank_n_out", 32'(blank_n_out), 32'd0);
            @(negedge Clk);
        end
        Reset_n = 1'b1;
        pix_en  = 1'b0;
        aq.delete();
        pq.delete();
        r     = '{1'b1, 24'h0, 1'b1, 1'b1, 1'b0};
        cur_a = '{1'b1, 9'd0};
        cur_p = r;
        pq.push_back(r);
        pq.push_back(r);
        mon_en = 1'b1;
    endtask

    // Monitor: pop on each strobe, compare outputs on every cycle (so frozen
    // outputs during pauses are checked too).
    always @(posedge Clk) begin
        if (mon_en) begin
            if (pix_en) begin
                if (aq.size() == 0 || pq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow actual=empty expected=entry t=%0t", $time);
                end else begin
                    cur_a = aq.pop_front();
                    cur_p = pq.pop_front();
                end
            end
            #1;
            if (cur_a.chk) check("read_address", 32'(read_address), 32'(cur_a.addr));
            if (cur_p.chk) check("rgb", {8'h0, Red, Green, Blue}, {8'h0, cur_p.rgb});
            check("hs_out", 32'(hs_out), 32'(cur_p.hs));
            check("vs_out", 32'(vs_out), 32'(cur_p.vs));
            check("blank_n_out", 32'(blank_n_out), 32'(cur_p.bl));
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 5'((i + 3) % 32);
        DrawX      = '0;
        DrawY      = '0;
        hs_in      = 1'b1;
        vs_in      = 1'b1;
        blank_n_in = 1'b0;
        pix_en     = 1'b0;
        Reset_n    = 1'b0;
        @(negedge Clk);
        do_reset(1'b0);

        // Frame 1: full frame, pause on line 5, wrap at line 524.
        for (int y = 0; y < 525; y++) run_line(y);

        // Frame 2: reset in the middle of line 200; tracking is only trusted
        // again after the next frame wrap.
        for (int y = 0; y < 200; y++) run_line(y);
        active_line(200, 0, 1);
        do_reset(1'b1);
        trust = 1'b0;
        active_line(200, 2, 12);
        for (int y = 201; y < 525; y++) run_line(y);
        trust = 1'b1;

        // Frame 3: first lines must read from row 0 again.
        for (int y = 0; y < 31; y++) run_line(y);
        strobe(799, 31, 1);
        strobe(799, 31, 1);
        repeat (2) @(negedge Clk);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
